// File: rtl/seq_det_prog.sv
// seq_det_prog: bit-serial detector for a programmable 1..PAT_W bit pattern, with overlap
// mode and a saturating match counter. Define SEQ_DET_REG_OUT_EN for a registered yout.
`default_nettype none

module seq_det_prog #(
  parameter int               PAT_W   = 8,
  parameter int               LEN_W   = 4,
  parameter int               CNT_W   = 8,
  parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(8'b0001_0110),
  parameter logic [LEN_W-1:0] RST_LEN = LEN_W'(5)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             xin,
  input  logic             xin_valid,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic [LEN_W-1:0] len_in,
  input  logic             overlap,
  input  logic             clr_cnt,
  output logic             yout,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cfg_err
);

  localparam logic [LEN_W:0] PAT_W_L = (LEN_W+1)'(PAT_W);

  logic [PAT_W-1:0] pat_reg;
  logic [LEN_W-1:0] len_reg;
  logic [LEN_W-1:0] fill;
  logic [PAT_W-2:0] hist;

  logic             accept;
  logic             load_ok;
  logic             filled;
  logic             match;
  logic             cnt_inc;
  logic [PAT_W-1:0] window;
  logic [PAT_W-1:0] mask;
  logic [LEN_W:0]   fill_p1;

  assign accept  = xin_valid & ~pat_load;
  assign load_ok = (len_in != '0) && ({1'b0, len_in} <= PAT_W_L);
  assign window  = {hist, xin};
  assign fill_p1 = {1'b0, fill} + 1'b1;
  assign filled  = fill_p1 >= {1'b0, len_reg};

  // Only the low len_reg bits of the window take part in the comparison.
  always_comb begin
    mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (i < int'(len_reg));
    end
  end

  assign match = accept & filled & (((window ^ pat_reg) & mask) == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pat_reg <= RST_PAT;
      len_reg <= RST_LEN;
      hist    <= '0;
      fill    <= '0;
      cfg_err <= 1'b0;
    end else if (pat_load) begin
      if (load_ok) begin
        pat_reg <= pat_in;
        len_reg <= len_in;
        hist    <= '0;
        fill    <= '0;
      end else begin
        cfg_err <= 1'b1;
      end
    end else if (xin_valid) begin
      hist <= window[PAT_W-2:0];
      // A non-overlapping match restarts the fill so the next match needs fresh bits.
      if (match && !overlap) begin
        fill <= '0;
      end else if (fill < len_reg) begin
        fill <= fill + 1'b1;
      end
    end
  end

`ifdef SEQ_DET_REG_OUT_EN
  logic yout_r;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      yout_r <= 1'b0;
    end else begin
      yout_r <= match;
    end
  end

  assign yout    = yout_r;
  assign cnt_inc = yout_r;
`else
  assign yout    = match;
  assign cnt_inc = match;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      match_cnt <= '0;
    end else if (clr_cnt) begin
      match_cnt <= cnt_inc ? CNT_W'(1) : '0;
    end else if (cnt_inc && !(&match_cnt)) begin
      match_cnt <= match_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: doc/seq_det_prog.md
Name: seq_det_prog

Overview:
- Parametrised successor to the team's fixed serial sequence detectors: one bit-serial input, run-time programmable pattern of 1..PAT_W bits, selectable overlap mode, saturating match counter.
- Sits between the serial front-end and the status/interrupt logic.
- Default configuration after reset detects "10110" with overlap.

Parameters:
- PAT_W, 8: maximum pattern length in bits (>=2).
- LEN_W, 4: width of length fields; must satisfy 2^LEN_W > PAT_W.
- CNT_W, 8: match counter width.
- RST_PAT, 8'b0001_0110: pattern after reset, right-aligned.
- RST_LEN, 5: pattern length after reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- xin  in  1  serial data bit.
- xin_valid  in  1  xin is sampled this cycle.
- pat_load  in  1  load pattern/length this cycle.
- pat_in  in  PAT_W  new pattern, right-aligned.
- len_in  in  LEN_W  new pattern length.
- overlap  in  1  1 = overlapping matches allowed, 0 = non-overlapping.
- clr_cnt  in  1  synchronous clear of match_cnt.
- yout  out  1  match pulse.
- match_cnt  out  CNT_W  saturating count of matches.
- cfg_err  out  1  sticky flag for a rejected load.

Behaviour:
- State:
  - pat_reg[PAT_W], len_reg[LEN_W].
  - hist[PAT_W-1] holds previously accepted bits; newest bit is in the LSB.
  - fill[LEN_W] counts accepted bits since the last flush, saturating at len_reg.
- Reset values: pat_reg=RST_PAT, len_reg=RST_LEN, hist=0, fill=0, match_cnt=0, cfg_err=0, yout=0.
- Bit order: first bit received corresponds to pat_reg[len_reg-1]; last bit corresponds to pat_reg[0].
- Match condition (Mealy, combinational from xin and registers), all must hold:
  - xin_valid=1
  - pat_load=0
  - fill >= len_reg-1
  - {hist[len_reg-2:0], xin} == pat_reg[len_reg-1:0]
  - yout=1 in the same cycle; there is no latency.
- Per accepted bit (xin_valid=1, pat_load=0):
  - hist shifts left with xin inserted at the LSB.
  - fill increments, saturating at len_reg.
- Non-overlap flush: if overlap=0 and the bit matches, fill<=0 (hist still shifts), so the next match needs len_reg fresh bits.
- Overlap mode: fill is never flushed by a match.
- Idle cycles (xin_valid=0): all state holds; yout=0.
- pat_load, accepted (1 <= len_in <= PAT_W):
  - pat_reg<=pat_in, len_reg<=len_in, hist<=0, fill<=0.
  - Any xin presented in the same cycle is discarded; yout=0.
- pat_load, rejected (len_in=0 or len_in>PAT_W):
  - pat_reg, len_reg, hist and fill are unchanged.
  - cfg_err<=1; it clears only on reset.
  - The xin in that cycle is still discarded.
- len_reg=1: match on every accepted bit equal to pat_reg[0]; hist is not compared.
- match_cnt:
  - Increments on each cycle with yout=1; saturates at 2^CNT_W-1.
  - clr_cnt alone sets it to 0.
  - clr_cnt together with a match sets it to 1.
- overlap may change on any cycle and takes effect on the current bit.
- Reset asserted mid-sequence: immediately restores all reset values; partial history is lost.

Optional Feature:
- Macro SEQ_DET_REG_OUT_EN.
- Defined:
  - yout is registered: it is high for one cycle, the cycle after the matching bit.
  - match_cnt increments on that same registered pulse.
  - Reset clears the yout register.
- Undefined: combinational Mealy yout as above, zero latency.

Test Plan:
1. After reset, overlap=1: stream 1,0,1,1,0 with xin_valid=1 every cycle -> yout=1 only on the 5th bit; match_cnt=1.
2. overlap=1, stream 1,0,1,1,0,1,1,0 -> yout on bits 5 and 8; match_cnt=2. Repeat after reset with overlap=0 -> yout on bit 5 only; match_cnt=1.
3. pat_load with pat_in=8'b0000_0111, len_in=3, then stream 1,1,1,1,1,1:
   - overlap=1 -> yout on bits 3,4,5,6.
   - overlap=0 -> yout on bits 3 and 6.
4. pat_load with len_in=0, then len_in=9 -> cfg_err=1 and pattern still 10110; stream 1,0,1,1,0 -> yout on bit 5. Also: a match bit coincident with a valid pat_load -> yout=0 and fill=0 afterwards.
5. CNT_W=2, pattern len 1 = "1", stream of six 1s -> match_cnt 1,2,3,3,3,3. Then clr_cnt together with a matching bit -> match_cnt=1.
6. Stream 1,0,1, assert reset_n=0 mid-cycle, release, then stream 1,0 -> no yout; full 1,0,1,1,0 -> yout on its 5th bit. Repeat scenario 1 with SEQ_DET_REG_OUT_EN defined -> yout one cycle after bit 5.
